// File: rtl/letc_core_pkg.sv
`default_nettype none
// ============================================================================
// letc_core_pkg : shared types for the LETC core memory subsystem
// Revision 1.0
// ============================================================================
package letc_core_pkg;

  typedef enum logic [1:0] {
    MSS_IDLE  = 2'd0,
    MSS_ISSUE = 2'd1,
    MSS_WAIT  = 2'd2
  } mss_state_e;

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } mss_src_e;

endpackage : letc_core_pkg
`default_nettype wire

// File: rtl/letc_core_mss_arbiter.sv
`default_nettype none
// ============================================================================
// letc_core_mss_arbiter : round-robin I/D arbiter onto one shared memory port
// Revision 1.0
// ============================================================================
module letc_core_mss_arbiter
  import letc_core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                i_ireq_valid,
  output logic                o_ireq_ready,
  input  logic [ADDR_W-1:0]   i_ireq_addr,
  output logic                o_iresp_valid,
  output logic [DATA_W-1:0]   o_iresp_rdata,
  output logic                o_iresp_err,

  input  logic                i_dreq_valid,
  output logic                o_dreq_ready,
  input  logic [ADDR_W-1:0]   i_dreq_addr,
  input  logic                i_dreq_we,
  input  logic [DATA_W-1:0]   i_dreq_wdata,
  input  logic [DATA_W/8-1:0] i_dreq_wstrb,
  output logic                o_dresp_valid,
  output logic [DATA_W-1:0]   o_dresp_rdata,
  output logic                o_dresp_err,

  output logic                o_mreq_valid,
  input  logic                i_mreq_ready,
  output logic [ADDR_W-1:0]   o_mreq_addr,
  output logic                o_mreq_we,
  output logic [DATA_W-1:0]   o_mreq_wdata,
  output logic [DATA_W/8-1:0] o_mreq_wstrb,
  output logic                o_mreq_src,
  input  logic                i_mresp_valid,
  input  logic [DATA_W-1:0]   i_mresp_rdata,
  input  logic                i_mresp_err,

  output logic                o_busy
);

  localparam int STRB_W = DATA_W / 8;

  mss_state_e          r_state;
  mss_state_e          w_state_next;
  mss_src_e            r_last_grant;
  mss_src_e            r_src;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                w_grant_i;
  logic                w_grant_d;
  logic                w_resp;

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      MSS_IDLE: begin
        // Grants are suppressed while reset is held so no ready leaks out.
        if (rst_n) begin
          if (i_ireq_valid && (!i_dreq_valid || r_last_grant == SRC_DATA)) begin
            w_grant_i = 1'b1;
          end else if (i_dreq_valid) begin
            w_grant_d = 1'b1;
          end
        end
        if (w_grant_i || w_grant_d) begin
          w_state_next = MSS_ISSUE;
        end
      end
      MSS_ISSUE: begin
        if (i_mreq_ready) begin
          w_state_next = MSS_WAIT;
        end
      end
      MSS_WAIT: begin
        if (i_mresp_valid) begin
          w_state_next = MSS_IDLE;
        end
      end
      default: w_state_next = MSS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= MSS_IDLE;
      r_last_grant <= SRC_DATA;
      r_src        <= SRC_INSTR;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_i) begin
        r_src        <= SRC_INSTR;
        r_last_grant <= SRC_INSTR;
        r_addr       <= i_ireq_addr;
        r_we         <= 1'b0;
        r_wdata      <= '0;
        r_wstrb      <= '0;
      end else if (w_grant_d) begin
        r_src        <= SRC_DATA;
        r_last_grant <= SRC_DATA;
        r_addr       <= i_dreq_addr;
        r_we         <= i_dreq_we;
        r_wdata      <= i_dreq_wdata;
        r_wstrb      <= i_dreq_wstrb;
      end
    end
  end

  assign w_resp        = (r_state == MSS_WAIT) && i_mresp_valid;

  assign o_ireq_ready  = w_grant_i;
  assign o_dreq_ready  = w_grant_d;

  assign o_mreq_valid  = (r_state == MSS_ISSUE);
  assign o_mreq_addr   = r_addr;
  assign o_mreq_we     = r_we;
  assign o_mreq_wdata  = r_wdata;
  assign o_mreq_wstrb  = r_wstrb;
  assign o_mreq_src    = r_src;

  assign o_iresp_valid = w_resp && (r_src == SRC_INSTR);
  assign o_iresp_rdata = o_iresp_valid ? i_mresp_rdata : '0;
  assign o_iresp_err   = o_iresp_valid ? i_mresp_err   : 1'b0;

  assign o_dresp_valid = w_resp && (r_src == SRC_DATA);
  assign o_dresp_rdata = o_dresp_valid ? i_mresp_rdata : '0;
  assign o_dresp_err   = o_dresp_valid ? i_mresp_err   : 1'b0;

  assign o_busy        = (r_state != MSS_IDLE);

endmodule : letc_core_mss_arbiter
`default_nettype wire

// File: tb/tb_letc_core_mss_arbiter.sv
`default_nettype none
// ============================================================================
// tb_letc_core_mss_arbiter : scoreboard bench for the I/D shared-port arbiter
// Revision 1.0
// ============================================================================
module tb_letc_core_mss_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_ireq_valid;
  logic        o_ireq_ready;
  logic [31:0] i_ireq_addr;
  logic        o_iresp_valid;
  logic [31:0] o_iresp_rdata;
  logic        o_iresp_err;
  logic        i_dreq_valid;
  logic        o_dreq_ready;
  logic [31:0] i_dreq_addr;
  logic        i_dreq_we;
  logic [31:0] i_dreq_wdata;
  logic [3:0]  i_dreq_wstrb;
  logic        o_dresp_valid;
  logic [31:0] o_dresp_rdata;
  logic        o_dresp_err;
  logic        o_mreq_valid;
  logic        i_mreq_ready;
  logic [31:0] o_mreq_addr;
  logic        o_mreq_we;
  logic [31:0] o_mreq_wdata;
  logic [3:0]  o_mreq_wstrb;
  logic        o_mreq_src;
  logic        i_mresp_valid;
  logic [31:0] i_mresp_rdata;
  logic        i_mresp_err;
  logic        o_busy;

  always #5 clk = ~clk;

  letc_core_mss_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ireq_valid(i_ireq_valid), .o_ireq_ready(o_ireq_ready), .i_ireq_addr(i_ireq_addr),
    .o_iresp_valid(o_iresp_valid), .o_iresp_rdata(o_iresp_rdata), .o_iresp_err(o_iresp_err),
    .i_dreq_valid(i_dreq_valid), .o_dreq_ready(o_dreq_ready), .i_dreq_addr(i_dreq_addr),
    .i_dreq_we(i_dreq_we), .i_dreq_wdata(i_dreq_wdata), .i_dreq_wstrb(i_dreq_wstrb),
    .o_dresp_valid(o_dresp_valid), .o_dresp_rdata(o_dresp_rdata), .o_dresp_err(o_dresp_err),
    .o_mreq_valid(o_mreq_valid), .i_mreq_ready(i_mreq_ready), .o_mreq_addr(o_mreq_addr),
    .o_mreq_we(o_mreq_we), .o_mreq_wdata(o_mreq_wdata), .o_mreq_wstrb(o_mreq_wstrb),
    .o_mreq_src(o_mreq_src), .i_mresp_valid(i_mresp_valid), .i_mresp_rdata(i_mresp_rdata),
    .i_mresp_err(i_mresp_err), .o_busy(o_busy)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        src;
  } req_t;

  typedef struct packed {
    logic        src;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  req_t  exp_req_q[$];
  resp_t exp_resp_q[$];
  int    n_vec = 0;
  int    n_fail = 0;
  int    d_rdy_cnt = 0;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a request or response
  initial begin : monitor
    req_t  a_req;
    resp_t a_resp;
    forever begin
      @(negedge clk);
      if (o_dreq_ready) d_rdy_cnt++;
      chk("protocol",
          80'({o_ireq_ready && o_dreq_ready,
               o_busy && (o_ireq_ready || o_dreq_ready),
               !o_iresp_valid && (o_iresp_rdata != 32'h0 || o_iresp_err),
               !o_dresp_valid && (o_dresp_rdata != 32'h0 || o_dresp_err),
               o_iresp_valid && o_dresp_valid}),
          80'd0);
      if (o_mreq_valid && i_mreq_ready) begin
        a_req = '{o_mreq_addr, o_mreq_we, o_mreq_wdata, o_mreq_wstrb, o_mreq_src};
        if (exp_req_q.size() == 0) chk("mreq_unexpected", 80'(a_req), 80'd0 - 80'd1);
        else chk("mreq", 80'(a_req), 80'(exp_req_q.pop_front()));
      end
      if (o_iresp_valid || o_dresp_valid) begin
        a_resp.src   = o_dresp_valid;
        a_resp.rdata = o_dresp_valid ? o_dresp_rdata : o_iresp_rdata;
        a_resp.err   = o_dresp_valid ? o_dresp_err : o_iresp_err;
        if (exp_resp_q.size() == 0) chk("resp_spurious", 80'(a_resp), 80'd0 - 80'd1);
        else chk("resp", 80'(a_resp), 80'(exp_resp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    i_ireq_valid = 1'b1; i_ireq_addr = 32'h0;
    i_dreq_valid = 1'b1; i_dreq_addr = 32'h0; i_dreq_we = 1'b0;
    i_dreq_wdata = 32'h0; i_dreq_wstrb = 4'h0;
    i_mreq_ready = 1'b0; i_mresp_valid = 1'b0; i_mresp_rdata = 32'h0; i_mresp_err = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_outputs",
        80'({o_busy, o_mreq_valid, o_mreq_addr, o_mreq_we, o_mreq_wdata, o_mreq_wstrb,
             o_mreq_src, o_iresp_valid, o_dresp_valid, o_ireq_ready, o_dreq_ready}),
        80'd0);
    i_ireq_valid = 1'b0;
    i_dreq_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Drives a request at the current cycle, checks its ready and pushes the expected grant.
  task automatic issue_req(input logic src, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] wstrb, input bit hold);
    req_t e;
    if (src) begin
      i_dreq_valid = 1'b1; i_dreq_addr = addr; i_dreq_we = we;
      i_dreq_wdata = wdata; i_dreq_wstrb = wstrb;
    end else begin
      i_ireq_valid = 1'b1; i_ireq_addr = addr;
    end
    @(negedge clk);
    chk(src ? "dreq_ready" : "ireq_ready", 80'({o_ireq_ready, o_dreq_ready}),
        src ? 80'd1 : 80'd2);
    e.addr  = addr;
    e.we    = src & we;
    e.wdata = src ? wdata : 32'h0;
    e.wstrb = src ? wstrb : 4'h0;
    e.src   = src;
    exp_req_q.push_back(e);
    tick();
    if (!hold) begin
      if (src) i_dreq_valid = 1'b0;
      else     i_ireq_valid = 1'b0;
    end
  endtask

  task automatic accept(input int rdy_dly, input bit spurious);
    chk("issue_valid", 80'(o_mreq_valid), 80'd1);
    for (int c = 0; c < rdy_dly; c++) begin
      if (spurious && c == 0) i_mresp_valid = 1'b1;
      @(negedge clk);
      if (exp_req_q.size() != 0)
        chk("mreq_stable",
            80'({o_mreq_valid, o_mreq_addr, o_mreq_we, o_mreq_wdata, o_mreq_wstrb, o_mreq_src}),
            80'({1'b1, exp_req_q[0]}));
      tick();
      i_mresp_valid = 1'b0;
    end
    i_mreq_ready = 1'b1;
    tick();
    i_mreq_ready = 1'b0;
  endtask

  task automatic respond(input int resp_dly, input logic src, input logic [31:0] rd,
                         input logic err);
    resp_t e;
    e.src = src; e.rdata = rd; e.err = err;
    exp_resp_q.push_back(e);
    repeat (resp_dly - 1) tick();
    i_mresp_valid = 1'b1; i_mresp_rdata = rd; i_mresp_err = err;
    tick();
    i_mresp_valid = 1'b0; i_mresp_rdata = 32'h0; i_mresp_err = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : stimulus
    int c0;
    do_reset();

    // Single instruction fetch, response two cycles into WAIT
    issue_req(1'b0, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 1'b0);
    accept(0, 1'b0);
    respond(2, 1'b0, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    chk("iresp_one_cycle", 80'({o_iresp_valid, o_busy}), 80'd0);
    tick();

    // Both requesters held from reset: grants alternate I, D, I, D
    do_reset();
    i_ireq_valid = 1'b1; i_ireq_addr = 32'h0000_0200;
    i_dreq_valid = 1'b1; i_dreq_addr = 32'h0000_0300; i_dreq_we = 1'b1;
    i_dreq_wdata = 32'hA5A5_0001; i_dreq_wstrb = 4'hF;
    for (int k = 0; k < 4; k++) begin
      req_t e;
      logic w;
      w = k[0];
      @(negedge clk);
      chk("rr_grant", 80'({o_ireq_ready, o_dreq_ready}), w ? 80'd1 : 80'd2);
      e.addr  = w ? 32'h0000_0300 : 32'h0000_0200;
      e.we    = w;
      e.wdata = w ? 32'hA5A5_0001 : 32'h0;
      e.wstrb = w ? 4'hF : 4'h0;
      e.src   = w;
      exp_req_q.push_back(e);
      tick();
      accept(0, 1'b0);
      respond(1, w, 32'h0000_1000 + 32'(k), 1'b0);
    end
    i_ireq_valid = 1'b0;
    i_dreq_valid = 1'b0;
    tick();

    // Store at top of address space with a 3-cycle stall and a spurious response during ISSUE
    c0 = d_rdy_cnt;
    issue_req(1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0000_0041, 4'h1, 1'b1);
    accept(3, 1'b1);
    respond(1, 1'b1, 32'h0, 1'b0);
    i_dreq_valid = 1'b0;
    @(negedge clk);
    chk("dreq_ready_pulses", 80'(d_rdy_cnt - c0), 80'd1);
    tick();

    // Spurious response while IDLE
    i_mresp_valid = 1'b1; i_mresp_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("idle_spurious", 80'({o_iresp_valid, o_dresp_valid, o_busy}), 80'd0);
    tick();
    i_mresp_valid = 1'b0; i_mresp_rdata = 32'h0;
    @(negedge clk);
    chk("idle_stays", 80'(o_busy), 80'd0);
    tick();

    // Reset while in WAIT, then a late response
    issue_req(1'b1, 32'h0000_0040, 1'b0, 32'h0, 4'h0, 1'b0);
    accept(0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    i_mresp_valid = 1'b1; i_mresp_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("late_resp_dropped", 80'({o_iresp_valid, o_dresp_valid, o_busy}), 80'd0);
    tick();
    i_mresp_valid = 1'b0; i_mresp_rdata = 32'h0;
    issue_req(1'b0, 32'h0000_0080, 1'b0, 32'h0, 4'h0, 1'b0);
    accept(0, 1'b0);
    respond(1, 1'b0, 32'h0BAD_F00D, 1'b0);

    // Data load that returns a bus error
    issue_req(1'b1, 32'h0000_0044, 1'b0, 32'h0, 4'h0, 1'b0);
    accept(1, 1'b0);
    respond(3, 1'b1, 32'h1234_5678, 1'b1);
    @(negedge clk);
    chk("err_done", 80'({o_dresp_valid, o_iresp_valid, o_busy}), 80'd0);
    tick();

    repeat (3) tick();
    chk("req_queue_drained", 80'(exp_req_q.size()), 80'd0);
    chk("resp_queue_drained", 80'(exp_resp_q.size()), 80'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_letc_core_mss_arbiter
`default_nettype wire
